// File: rtl/arbitro_ula_pkg.sv
// Shared constants for arbitro_ula: ALU opcodes, FSM state encoding and a
// small helper that turns a requester id into its one-hot bit.
package arbitro_ula_pkg;

  localparam logic [1:0] OP_SOMA = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_OR   = 2'b11;

  localparam logic [1:0] OCIOSO   = 2'b00;
  localparam logic [1:0] EXECUTA  = 2'b01;
  localparam logic [1:0] RESPOSTA = 2'b10;

  function automatic logic [1:0] um_quente(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ula_nucleo.sv
// Purely combinational ALU core: 4-way operation select on op.
// Add/subtract wrap modulo 2^LARGURA.
module ula_nucleo
  import arbitro_ula_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic [1:0]         op,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  output logic [LARGURA-1:0] resultado
);

  // operation select
  always_comb begin
    resultado = {LARGURA{1'b0}};
    case (op)
      OP_SOMA: resultado = a + b;
      OP_SUB:  resultado = a - b;
      OP_AND:  resultado = a & b;
      OP_OR:   resultado = a | b;
      default: resultado = {LARGURA{1'b0}};
    endcase
  end

endmodule

// File: rtl/arbitro_ula.sv
// Two-requester arbiter sharing one ALU (OCIOSO -> EXECUTA -> RESPOSTA).
// Define ARBITRO_ULA_ROUND_ROBIN_EN for round-robin ties; default is fixed priority (requester 0).
module arbitro_ula
  import arbitro_ula_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           req_valido,
  output logic [1:0]           req_pronto,
  input  logic [3:0]           req_op,
  input  logic [2*LARGURA-1:0] req_a,
  input  logic [2*LARGURA-1:0] req_b,
  output logic [1:0]           resp_valido,
  input  logic [1:0]           resp_pronto,
  output logic [LARGURA-1:0]   resp_dado,
  output logic                 resp_zero,
  output logic                 ocupado
);

  logic [1:0]         estado_r;
  logic [1:0]         op_r;
  logic [LARGURA-1:0] a_r;
  logic [LARGURA-1:0] b_r;
  logic               dono_r;
  logic [1:0]         resp_valido_r;
  logic [LARGURA-1:0] resp_dado_r;
  logic               resp_zero_r;
  logic               ocupado_r;

  logic [1:0]         ganho_s;
  logic               aceita_s;
  logic               ganhador_s;
  logic [LARGURA-1:0] resultado_s;

`ifdef ARBITRO_ULA_ROUND_ROBIN_EN
  logic ultimo_r;

  // round-robin winner: on a tie the requester not granted last wins
  always_comb begin
    if (req_valido == 2'b11) begin
      ganho_s = ultimo_r ? 2'b01 : 2'b10;
    end else begin
      ganho_s = req_valido;
    end
  end

  // last-grant pointer, moves only on acceptance
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ultimo_r <= 1'b1;
    end else if (aceita_s) begin
      ultimo_r <= ganhador_s;
    end
  end
`else
  // fixed priority: requester 0 always wins
  always_comb begin
    if (req_valido[0]) begin
      ganho_s = 2'b01;
    end else if (req_valido[1]) begin
      ganho_s = 2'b10;
    end else begin
      ganho_s = 2'b00;
    end
  end
`endif

  // grant only visible while idle
  always_comb begin
    if (estado_r == OCIOSO) begin
      req_pronto = ganho_s;
    end else begin
      req_pronto = 2'b00;
    end
  end

  assign aceita_s   = |(req_valido & req_pronto);
  assign ganhador_s = req_pronto[1];

  ula_nucleo #(
    .LARGURA (LARGURA)
  ) u_nucleo (
    .op        (op_r),
    .a         (a_r),
    .b         (b_r),
    .resultado (resultado_s)
  );

  // control FSM with latched request and registered response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_r      <= OCIOSO;
      op_r          <= 2'b00;
      a_r           <= {LARGURA{1'b0}};
      b_r           <= {LARGURA{1'b0}};
      dono_r        <= 1'b0;
      resp_valido_r <= 2'b00;
      resp_dado_r   <= {LARGURA{1'b0}};
      resp_zero_r   <= 1'b1;
      ocupado_r     <= 1'b0;
    end else begin
      case (estado_r)
        OCIOSO: begin
          if (aceita_s) begin
            op_r      <= ganhador_s ? req_op[3:2] : req_op[1:0];
            a_r       <= ganhador_s ? req_a[2*LARGURA-1:LARGURA] : req_a[LARGURA-1:0];
            b_r       <= ganhador_s ? req_b[2*LARGURA-1:LARGURA] : req_b[LARGURA-1:0];
            dono_r    <= ganhador_s;
            estado_r  <= EXECUTA;
            ocupado_r <= 1'b1;
          end
        end
        EXECUTA: begin
          resp_dado_r   <= resultado_s;
          resp_zero_r   <= (resultado_s == {LARGURA{1'b0}});
          resp_valido_r <= um_quente(dono_r);
          estado_r      <= RESPOSTA;
        end
        RESPOSTA: begin
          // the non-owning resp_pronto bit is deliberately ignored
          if (resp_pronto[dono_r]) begin
            resp_valido_r <= 2'b00;
            estado_r      <= OCIOSO;
            ocupado_r     <= 1'b0;
          end
        end
        default: begin
          estado_r      <= OCIOSO;
          resp_valido_r <= 2'b00;
          ocupado_r     <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valido = resp_valido_r;
  assign resp_dado   = resp_dado_r;
  assign resp_zero   = resp_zero_r;
  assign ocupado     = ocupado_r;

endmodule
